// File: rtl/tt_uio_arb_pkg.sv
// Shared types and sizing helpers for the uio pad-bus arbiter.
package tt_uio_arb_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    // Minimum-1 bit width able to index n entries.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tt_rr_pick.sv
// Rotating-priority picker: first set request at or after ptr_i, wrapping.
module tt_rr_pick
    import tt_uio_arb_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_c,
    output logic             any_c
);

    int unsigned cand;

    // ptr_i is always < NREQ, so one conditional subtract is a full modulo.
    always_comb begin
        idx_c = '0;
        any_c = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr_i) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!any_c && req_i[IDX_W'(cand)]) begin
                idx_c = IDX_W'(cand);
                any_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tt_uio_bus_arbiter.sv
// Round-robin owner of the shared uio pad bus with per-owner direction,
// enforced all-input turnaround gap and a hold-time cap under contention.
module tt_uio_bus_arbiter
    import tt_uio_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned TURN_CYC = 1,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   wr,
    input  logic [NREQ*8-1:0] wdata,
    input  logic [7:0]        uio_in,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    output logic [7:0]        rdata,
    output logic              rvalid,
    output logic              busy
);

    localparam int unsigned IDX_W  = idx_w(NREQ);
    localparam int unsigned HOLD_W = idx_w(MAX_HOLD);
    localparam int unsigned GAP_W  = idx_w(TURN_CYC);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [7:0]        uio_out_q, uio_out_d;
    logic [7:0]        uio_oe_q, uio_oe_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              busy_q, busy_d;

    logic [IDX_W-1:0]  win_idx_c;
    logic              win_any_c;
    logic [7:0]        own_wdata_c;
    logic [NREQ-1:0]   own_oh_c;
    logic              hold_top_c;
    logic              release_c;

    tt_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .idx_c (win_idx_c),
        .any_c (win_any_c)
    );

    always_comb begin
        own_wdata_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (owner_q == IDX_W'(i)) own_wdata_c = wdata[8*i +: 8];
        end
    end

    assign own_oh_c   = NREQ'(1) << owner_q;
    assign hold_top_c = (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign release_c  = !req[owner_q] || !ena || (hold_top_c && |(req & ~own_oh_c));

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        gnt_d     = gnt_q;
        uio_out_d = uio_out_q;
        uio_oe_d  = uio_oe_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                uio_oe_d = 8'h00;
                if (ena && win_any_c) begin
                    state_d = ST_OWN;
                    owner_d = win_idx_c;
                    gnt_d   = NREQ'(1) << win_idx_c;
                    hold_d  = '0;
                end
            end
            ST_OWN: begin
                if (release_c) begin
                    // Release edge carries no drive or sample update.
                    state_d  = ST_GAP;
                    gap_d    = '0;
                    gnt_d    = '0;
                    uio_oe_d = 8'h00;
                    rr_ptr_d = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + IDX_W'(1);
                end else begin
                    hold_d = hold_top_c ? '0 : hold_q + HOLD_W'(1);
                    if (wr[owner_q]) begin
                        uio_out_d = own_wdata_c;
                        uio_oe_d  = 8'hFF;
                    end else begin
                        uio_oe_d = 8'h00;
                        rdata_d  = uio_in;
                        rvalid_d = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                gnt_d    = '0;
                uio_oe_d = 8'h00;
                if (gap_q == GAP_W'(TURN_CYC - 1)) state_d = ST_IDLE;
                else                              gap_d   = gap_q + GAP_W'(1);
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                uio_oe_d = 8'h00;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            hold_q    <= '0;
            gap_q     <= '0;
            gnt_q     <= '0;
            uio_out_q <= '0;
            uio_oe_q  <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            gnt_q     <= gnt_d;
            uio_out_q <= uio_out_d;
            uio_oe_q  <= uio_oe_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign uio_out = uio_out_q;
    assign uio_oe  = uio_oe_q;
    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_tt_uio_bus_arbiter.sv
// Bench for tt_uio_bus_arbiter: tenure-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tt_uio_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int TURN_CYC = 1;
    localparam int MAX_HOLD = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ena = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   wr = '0;
    logic [NREQ*8-1:0] wdata = '0;
    logic [7:0]        uio_in = '0;
    logic [NREQ-1:0]   gnt;
    logic [7:0]        uio_out;
    logic [7:0]        uio_oe;
    logic [7:0]        rdata;
    logic              rvalid;
    logic              busy;

    int n_pass  = 0;
    int n_total = 0;

    tt_uio_bus_arbiter #(
        .NREQ     (NREQ),
        .TURN_CYC (TURN_CYC),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .req     (req),
        .wr      (wr),
        .wdata   (wdata),
        .uio_in  (uio_in),
        .gnt     (gnt),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .rdata   (rdata),
        .rvalid  (rvalid),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: who owns the bus, for how long, and what the pads must show.
    int              m_mode;    // 0 free, 1 owned, 2 turnaround
    int              m_owner;
    int              m_ptr;
    int              m_tenure;
    int              m_gap_left;
    logic [NREQ-1:0] e_gnt;
    logic [7:0]      e_out, e_oe, e_rdata;
    logic            e_rvalid, e_busy;
    bit              started = 0;

    task automatic model_reset();
        m_mode = 0; m_owner = 0; m_ptr = 0; m_tenure = 0; m_gap_left = 0;
        e_gnt = '0; e_out = '0; e_oe = '0; e_rdata = '0; e_rvalid = 0; e_busy = 0;
    endtask

    task automatic model_step();
        int  w;
        bit  others, give_up;
        e_rvalid = 0;
        case (m_mode)
            0: begin
                e_oe = 8'h00;
                w = -1;
                for (int k = 0; k < NREQ; k++) begin
                    int c = (m_ptr + k) % NREQ;
                    if (req[c] && w < 0) w = c;
                end
                if (ena && w >= 0) begin
                    m_mode = 1; m_owner = w; m_tenure = 0;
                    e_gnt = NREQ'(1 << w);
                end
            end
            1: begin
                others  = (req & ~NREQ'(1 << m_owner)) != 0;
                give_up = !req[m_owner] || !ena ||
                          ((m_tenure % MAX_HOLD) == MAX_HOLD - 1 && others);
                if (give_up) begin
                    m_mode = 2; m_gap_left = TURN_CYC;
                    e_gnt = '0; e_oe = 8'h00;
                    m_ptr = (m_owner + 1) % NREQ;
                end else begin
                    if (wr[m_owner]) begin
                        e_out = wdata[8*m_owner +: 8];
                        e_oe  = 8'hFF;
                    end else begin
                        e_oe = 8'h00; e_rdata = uio_in; e_rvalid = 1;
                    end
                    m_tenure++;
                end
            end
            default: begin
                e_gnt = '0; e_oe = 8'h00;
                m_gap_left--;
                if (m_gap_left == 0) m_mode = 0;
            end
        endcase
        e_busy = (m_mode != 0);
    endtask

    // Advance the model on each edge, then compare every DUT output 1 time unit later.
    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
        started = 1;
        #1;
        if (started) begin
            chk("gnt",     32'(gnt),      32'(e_gnt));
            chk("uio_oe",  32'(uio_oe),   32'(e_oe));
            chk("uio_out", 32'(uio_out),  32'(e_out));
            chk("rdata",   32'(rdata),    32'(e_rdata));
            chk("rvalid",  32'(rvalid),   32'(e_rvalid));
            chk("busy",    32'(busy),     32'(e_busy));
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("oe_legal",    32'(uio_oe == 8'h00 || uio_oe == 8'hFF), 32'd1);
            chk("oe_needs_gnt", 32'(uio_oe == 8'h00 || gnt != '0), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_gnt(input string name);
        int n = 0;
        while (gnt == '0 && n < 100) begin tick(); n++; end
        if (n >= 100) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || gnt != '0) && n < 100) begin tick(); n++; end
        if (n >= 100) chk("idle_timeout", 32'd0, 32'd1);
        tick();
    endtask

    logic [NREQ-1:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        int cnt;
        int z;

        repeat (3) tick();
        chk("reset_gnt",  32'(gnt),    32'h0);
        chk("reset_oe",   32'(uio_oe), 32'h00);
        chk("reset_busy", 32'(busy),   32'h0);
        rst_n = 1'b1;
        tick();

        // Write by requester 1 for three cycles.
        req = 4'b0010; wr = 4'b0010; wdata[15:8] = 8'hA5;
        tick();
        chk("wr_gnt", 32'(gnt), 32'h2);
        chk("wr_oe_first", 32'(uio_oe), 32'h00);
        tick();
        chk("wr_oe", 32'(uio_oe), 32'hFF);
        chk("wr_out", 32'(uio_out), 32'hA5);
        tick();
        req = '0;
        tick();
        chk("wr_rel_oe", 32'(uio_oe), 32'h00);
        chk("wr_rel_gnt", 32'(gnt), 32'h0);
        chk("wr_rel_busy", 32'(busy), 32'h1);
        wait_idle();

        // Read by requester 2: samples appear one cycle after uio_in.
        req = 4'b0100; wr = '0; uio_in = 8'h3C;
        tick();
        chk("rd_gnt", 32'(gnt), 32'h4);
        tick();
        chk("rd_data0", 32'(rdata), 32'h3C);
        chk("rd_valid0", 32'(rvalid), 32'h1);
        uio_in = 8'h3D;
        tick();
        chk("rd_data1", 32'(rdata), 32'h3D);
        uio_in = 8'h3E;
        tick();
        chk("rd_data2", 32'(rdata), 32'h3E);
        chk("rd_oe", 32'(uio_oe), 32'h00);
        req = '0;
        tick();
        chk("rd_rel_valid", 32'(rvalid), 32'h0);
        wait_idle();

        // Reset while requester 0 drives the pads.
        req = 4'b0001; wr = 4'b0001; wdata[7:0] = 8'h5A;
        tick();
        tick();
        chk("rst_pre_oe", 32'(uio_oe), 32'hFF);
        rst_n = 1'b0;
        #1;
        chk("rst_async_oe",   32'(uio_oe), 32'h00);
        chk("rst_async_gnt",  32'(gnt),    32'h0);
        chk("rst_async_busy", 32'(busy),   32'h0);
        tick();
        req = '0;
        rst_n = 1'b1;
        tick();

        // All four requesting continuously: strict rotation with capped tenure.
        req = 4'b1111; wr = 4'b1111; wdata = 32'h44332211;
        for (int j = 0; j < 5; j++) begin
            wait_gnt("rr_wait");
            chk("rr_gnt", 32'(gnt), 32'(rr_seq[j]));
            if (j < 4) begin
                cnt = 0;
                while (gnt == rr_seq[j] && cnt < 100) begin cnt++; tick(); end
                chk("rr_hold", 32'(cnt), 32'd16);
                z = 0;
                while (gnt == '0 && z < 100) begin z++; tick(); end
                chk("rr_gap", 32'(z), 32'd2);
            end
        end
        req = '0;
        wait_idle();

        // Sole requester keeps the bus past the hold cap.
        req = 4'b1000; wr = '0; uio_in = 8'h77;
        tick();
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (gnt == 4'b1000) cnt++;
            tick();
        end
        chk("solo_hold", 32'(cnt), 32'd40);
        req = '0;
        wait_idle();

        // ena gating: no grant while low, forced release, resume from rr pointer.
        ena = 1'b0; req = 4'b0101; wr = 4'b0101; wdata = 32'h00C300C1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (gnt != '0) cnt++;
            tick();
        end
        chk("ena_block", 32'(cnt), 32'd0);
        ena = 1'b1;
        tick();
        chk("ena_gnt0", 32'(gnt), 32'h1);
        tick();
        chk("ena_oe", 32'(uio_oe), 32'hFF);
        chk("ena_out", 32'(uio_out), 32'hC1);
        ena = 1'b0;
        tick();
        chk("ena_rel_gnt", 32'(gnt), 32'h0);
        chk("ena_rel_oe", 32'(uio_oe), 32'h00);
        chk("ena_rel_busy", 32'(busy), 32'h1);
        ena = 1'b1;
        wait_gnt("ena_resume");
        chk("ena_resume_gnt", 32'(gnt), 32'h4);
        req = '0;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
